sw_irq_ctrl: RTL and testbench
==============================

Name: sw_irq_ctrl

Overview:
- Avalon-MM slave controller in the FPGA fabric that turns the 4 board switches into interrupt requests for the HPS.
- Drives the 4 LEDs from a software-written register.
- Synchronizes and optionally debounces the switches, then detects edges into a sticky capture register.
- Masks the capture register and raises a level IRQ that is connected to the HPS f2h_irq line.
- Sits between the switch/LED pins and the HPS lightweight bridge, inside the hps system.

Parameters:
- N_SW, 4, number of switch inputs and LED outputs
- DEBOUNCE_CYCLES, 50000, cycles a synchronized input must hold stable before acceptance (1 ms at 50 MHz); minimum 2
- EDGE_MODE, 2, 0 = rising only, 1 = falling only, 2 = both edges
- LED_RESET, 0, LED register value after reset

Ports:
- clk_clk  in  1  system clock; the only clock
- reset_reset_n  in  1  synchronous active-low reset
- avs_address  in  2  word address of the register
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- sw_in  in  N_SW  raw asynchronous switch pins
- led_out  out  N_SW  LED drive
- irq  out  1  active-high level interrupt to the HPS

Behaviour:
- Reset: the single clock is clk_clk and the reset is reset_reset_n, synchronous and active-low (sampled only on a clk_clk rising edge). All state is cleared by reset: sync flops, debounce counters, stable value, edge_cap, irq_mask. After reset, avs_readdata = 0, irq = 0, led_out = LED_RESET.
- Input synchronization: 2-flop synchronizer per bit feeding sw_sync.
- Debounce (macro enabled): the per-bit counter clears whenever sw_sync equals stable. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 and sw_sync still differs, stable takes the sw_sync bit and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge detect: stable_d is stable delayed 1 cycle.
  - rise = stable & ~stable_d
  - fall = ~stable & stable_d
  - The selected edge set is OR'd into edge_cap (sticky).
- Register map, 32-bit words, unused bits read 0:
  - 0 DATA (RO): stable value.
  - 1 MASK (RW): irq_mask[N_SW-1:0].
  - 2 EDGE (R/W1C): edge_cap. Writing 1 clears a bit. If a new edge and a W1C on the same bit occur in the same cycle, the set wins (the bit stays 1).
  - 3 LED (RW): led register, drives led_out directly.
- Reads: avs_readdata is registered with read latency 1 and no waitrequest. It holds its last value when avs_read = 0. Reads have no side effects.
- Writes: take effect on the cycle the strobe is sampled. A read and a write in the same cycle are legal. The read returns the pre-write value.
- IRQ: irq is registered, irq = |(edge_cap & irq_mask), i.e. 1 cycle after the contributing register updates. It is a level output that stays high until software clears the edge or masks it.
- End-to-end latency with debounce: a switch change held stable reaches edge_cap 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the pin changes; irq follows 1 cycle later.
- Masking: changing MASK with pending edge_cap bits updates irq on the next cycle. Edges are captured regardless of the mask.
- Mid-operation reset: reset forces all state to reset values. No edge is generated when stable returns to 0, because stable_d is reset together with stable.

Optional Feature:
- Macro: SW_IRQ_CTRL_DEBOUNCE_EN.
- Defined: the per-bit sw_debounce instances are present as described in Behaviour.
- Undefined: no counters are built and stable = sw_sync. An edge reaches edge_cap 3 cycles after the pin changes. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared package sw_irq_pkg holds:
  - register offset constants REG_DATA = 0, REG_MASK = 1, REG_EDGE = 2, REG_LED = 3
  - edge-mode constants EDGE_RISE, EDGE_FALL, EDGE_BOTH
- One sub-module, sw_debounce: 1-bit synchronizer plus counter with parameter DEBOUNCE_CYCLES. It is instantiated N_SW times via generate.

Test Plan (DEBOUNCE_CYCLES = 8 for simulation):
- Reset then read all 4 registers -> DATA 0, MASK 0, EDGE 0, LED = LED_RESET; irq = 0.
- Write LED = 0xA -> led_out = 4'b1010 on the next cycle; reading LED returns 0x0000000A.
- MASK = 0xF, EDGE_MODE = 2; raise sw_in[0] and hold -> EDGE bit0 set 11 cycles after the pin edge, irq high 1 cycle later. W1C 0x1 -> irq low 1 cycle after the clear.
- Toggle sw_in[2] for 5 cycles then back (debounce enabled) -> DATA and EDGE unchanged, irq stays 0.
- Edge on sw_in[1] with MASK = 0 -> EDGE = 0x2 and irq = 0. Then write MASK = 0x2 -> irq = 1 one cycle later.
- W1C on bit3 in the same cycle a new bit3 edge arrives -> EDGE bit3 remains 1 and irq remains asserted.

Source files
------------

// File: rtl/sw_irq_pkg.sv
// Shared definitions for the switch-to-IRQ controller: register offsets,
// edge-mode codes and the Avalon-MM request bundle.
package sw_irq_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_LED  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } avs_req_t;

  // Returns {fall_en, rise_en} for an edge-mode code.
  function automatic logic [1:0] edge_sel(input int mode);
    case (mode)
      EDGE_RISE: edge_sel = 2'b01;
      EDGE_FALL: edge_sel = 2'b10;
      default:   edge_sel = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer, then an optional hold-time debounce
// counter when SW_IRQ_CTRL_DEBOUNCE_EN is defined (otherwise stable = sync).
module sw_debounce
  import sw_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [1:0] sync_q;
  logic       sw_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pin};
  end

  assign sw_sync = sync_q[1];

`ifdef SW_IRQ_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          stable_q;

  // Counter only runs while the synced value disagrees with the accepted one;
  // any agreement restarts the hold window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sw_sync == stable_q) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= sw_sync;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sw_sync;
`endif

endmodule

// File: rtl/sw_irq_ctrl.sv
// Avalon-MM switch/LED controller: per-bit sync+debounce, sticky edge capture,
// masked level IRQ. Debounce counters built only with SW_IRQ_CTRL_DEBOUNCE_EN.
module sw_irq_ctrl
  import sw_irq_pkg::*;
#(
  parameter int              N_SW            = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_MODE       = 2,
  parameter logic [N_SW-1:0] LED_RESET       = '0
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [1:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] led_out,
  output logic            irq
);

  localparam logic [1:0] SEL = edge_sel(EDGE_MODE);

  avs_req_t        req;
  logic [N_SW-1:0] stable, stable_d;
  logic [N_SW-1:0] rise, fall, edge_ev, w1c;
  logic [N_SW-1:0] edge_cap, irq_mask, led_q;
  logic [31:0]     rd_mux, rdata_q;
  logic            irq_q;
  logic            unused_wdata;

  assign req = '{rd: avs_read, wr: avs_write, addr: avs_address, wdata: avs_writedata};
  assign unused_wdata = ^req.wdata[31:N_SW];

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .pin    (sw_in[i]),
      .stable (stable[i])
    );
  end

  assign rise    = stable & ~stable_d;
  assign fall    = ~stable & stable_d;
  assign edge_ev = (rise & {N_SW{SEL[0]}}) | (fall & {N_SW{SEL[1]}});
  assign w1c     = (req.wr && req.addr == REG_EDGE) ? req.wdata[N_SW-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      REG_DATA: rd_mux[N_SW-1:0] = stable;
      REG_MASK: rd_mux[N_SW-1:0] = irq_mask;
      REG_EDGE: rd_mux[N_SW-1:0] = edge_cap;
      default:  rd_mux[N_SW-1:0] = led_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      stable_d <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      led_q    <= LED_RESET;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      stable_d <= stable;
      // New edges are OR'd after the clear so a coincident set survives.
      edge_cap <= (edge_cap & ~w1c) | edge_ev;
      if (req.wr && req.addr == REG_MASK) irq_mask <= req.wdata[N_SW-1:0];
      if (req.wr && req.addr == REG_LED)  led_q    <= req.wdata[N_SW-1:0];
      if (req.rd) rdata_q <= rd_mux;
      irq_q <= |(edge_cap & irq_mask);
    end
  end

  assign avs_readdata = rdata_q;
  assign led_out      = led_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_sw_irq_ctrl.sv
// Directed bench for sw_irq_ctrl with a history-based reference model;
// expected latencies follow SW_IRQ_CTRL_DEBOUNCE_EN when it is defined.
module tb_sw_irq_ctrl;

  localparam int         N    = 4;
  localparam int         DEB  = 8;
  localparam int         MODE = 2;
  localparam logic [3:0] LEDR = 4'h5;
`ifdef SW_IRQ_CTRL_DEBOUNCE_EN
  localparam bit         DEB_ON  = 1'b1;
  localparam int         LAT     = 2 + DEB + 1;
  localparam logic [3:0] GL_EDGE = 4'h0;
  localparam logic       GL_IRQ  = 1'b0;
`else
  localparam bit         DEB_ON  = 1'b0;
  localparam int         LAT     = 3;
  localparam logic [3:0] GL_EDGE = 4'h4;
  localparam logic       GL_IRQ  = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        avs_read, avs_write;
  logic [31:0] wdata, avs_readdata;
  logic [3:0]  sw_in, led_out;
  logic        irq;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sw_irq_ctrl #(
    .N_SW(N), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(MODE), .LED_RESET(LEDR)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs_address   (addr),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (wdata),
    .avs_readdata  (avs_readdata),
    .sw_in         (sw_in),
    .led_out       (led_out),
    .irq           (irq)
  );

  // Reference model. hist[i] is the synchronized pin value i+1 cycles back;
  // a debounced bit flips once the last DEB synced samples all disagree with it.
  logic [3:0]  m_s1, m_sync, m_stab, m_stab_d, m_edge, m_mask, m_led;
  logic [31:0] m_rd;
  logic        m_irq;
  logic [3:0]  hist [DEB];
  logic [3:0]  n_stab, ev, w1c;
  logic [31:0] rv;

  always_comb begin
    n_stab = m_stab;
    if (DEB_ON) begin
      for (int b = 0; b < N; b++) begin
        automatic bit all_diff = 1'b1;
        for (int i = 0; i < DEB; i++)
          if (hist[i][b] == m_stab[b]) all_diff = 1'b0;
        if (all_diff) n_stab[b] = ~m_stab[b];
      end
    end else begin
      n_stab = m_s1;
    end
    case (MODE)
      0:       ev = m_stab & ~m_stab_d;
      1:       ev = ~m_stab & m_stab_d;
      default: ev = m_stab ^ m_stab_d;
    endcase
    w1c = (avs_write && addr == 2'd2) ? wdata[3:0] : 4'h0;
    case (addr)
      2'd0:    rv = {28'h0, m_stab};
      2'd1:    rv = {28'h0, m_mask};
      2'd2:    rv = {28'h0, m_edge};
      default: rv = {28'h0, m_led};
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 <= '0; m_sync <= '0; m_stab <= '0; m_stab_d <= '0;
      m_edge <= '0; m_mask <= '0; m_led <= LEDR; m_rd <= '0; m_irq <= 1'b0;
      for (int i = 0; i < DEB; i++) hist[i] <= '0;
    end else begin
      m_s1     <= sw_in;
      m_sync   <= m_s1;
      hist[0]  <= m_s1;
      for (int i = 1; i < DEB; i++) hist[i] <= hist[i-1];
      m_stab   <= n_stab;
      m_stab_d <= m_stab;
      m_edge   <= (m_edge & ~w1c) | ev;
      m_irq    <= |(m_edge & m_mask);
      if (avs_read) m_rd <= rv;
      if (avs_write && addr == 2'd1) m_mask <= wdata[3:0];
      if (avs_write && addr == 2'd3) m_led  <= wdata[3:0];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_irq", {31'h0, irq}, {31'h0, m_irq});
      check("model_led", {28'h0, led_out}, {28'h0, m_led});
      check("model_rdata", avs_readdata, m_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    avs_read = 1'b1; addr = a;
    @(negedge clk);
    avs_read = 1'b0;
    check(nm, avs_readdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; avs_read = 1'b0; avs_write = 1'b0; wdata = '0; sw_in = '0;
    tick(3);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check("irq_rst", {31'h0, irq}, 32'h0);
    check("led_rst", {28'h0, led_out}, {28'h0, LEDR});
    rd(2'd0, 32'h0, "data_rst");
    rd(2'd1, 32'h0, "mask_rst");
    rd(2'd2, 32'h0, "edge_rst");
    rd(2'd3, {28'h0, LEDR}, "ledreg_rst");

    // LED write; upper write bits are dropped
    wr(2'd3, 32'hFFFF_FFFA);
    check("led_out_a", {28'h0, led_out}, 32'hA);
    rd(2'd3, 32'h0000_000A, "ledreg_a");

    // Rising edge on bit0, all bits unmasked
    wr(2'd1, 32'hF);
    sw_in[0] = 1'b1;
    tick(LAT - 1);
    avs_read = 1'b1; addr = 2'd2;
    @(negedge clk);
    check("edge0_early", avs_readdata, 32'h0);
    check("irq0_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    avs_read = 1'b0;
    check("edge0_set", avs_readdata, 32'h1);
    check("irq0_set", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    check("irq0_hold", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq0_clr", {31'h0, irq}, 32'h0);

    // Short glitch on bit2
    sw_in[2] = 1'b1;
    tick(5);
    sw_in[2] = 1'b0;
    tick(LAT + 4);
    rd(2'd0, 32'h1, "data_glitch");
    rd(2'd2, {28'h0, GL_EDGE}, "edge_glitch");
    check("irq_glitch", {31'h0, irq}, {31'h0, GL_IRQ});
    wr(2'd2, 32'hF);
    tick(2);

    // Masked edge on bit1, then unmask with a same-cycle read of MASK
    wr(2'd1, 32'h0);
    sw_in[1] = 1'b1;
    tick(LAT + 2);
    rd(2'd2, 32'h2, "edge_masked");
    check("irq_masked", {31'h0, irq}, 32'h0);
    avs_read = 1'b1; avs_write = 1'b1; addr = 2'd1; wdata = 32'h2;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("mask_rw_old", avs_readdata, 32'h0);
    check("irq_unmask_pre", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("irq_unmask", {31'h0, irq}, 32'h1);

    // W1C of bit3 coinciding with a new bit3 (falling) edge
    wr(2'd2, 32'h2);
    wr(2'd1, 32'hA);
    sw_in[3] = 1'b1;
    tick(LAT + 4);
    check("irq_bit3", {31'h0, irq}, 32'h1);
    sw_in[3] = 1'b0;
    tick(LAT - 1);
    wr(2'd2, 32'h8);
    check("irq_setwins_0", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_setwins_1", {31'h0, irq}, 32'h1);
    rd(2'd2, 32'h8, "edge_setwins");

    // Mid-operation reset; stable re-acquires held switches afterwards
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    rd(2'd2, 32'h0, "edge_after_rst");
    rd(2'd1, 32'h0, "mask_after_rst");
    check("led_after_rst", {28'h0, led_out}, {28'h0, LEDR});
    tick(LAT + 3);
    rd(2'd0, 32'h3, "data_resync");
    rd(2'd2, 32'h3, "edge_resync");
    check("irq_resync", {31'h0, irq}, 32'h0);

    tick(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
